// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - bus interface for the scoreboarded register file
//
// Purpose : groups the write, reserve, read, PC and flag signals of reg_file_sb.
// Modports: master drives enables/indices/data and observes read data;
//           slave is the register file side.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
);
    logic              in_enable;
    logic [SEL_W-1:0]  sel_in;
    logic [DATA_W-1:0] in_reg;
    logic              ld_enable;
    logic [SEL_W-1:0]  ld_sel;
    logic [DATA_W-1:0] ld_data;
    logic              rsv_enable;
    logic [SEL_W-1:0]  rsv_sel;
    logic [SEL_W-1:0]  sel_p0;
    logic [SEL_W-1:0]  sel_p1;
    logic [DATA_W-1:0] p0;
    logic [DATA_W-1:0] p1;
    logic              p0_busy;
    logic              p1_busy;
    logic              pc_enable;
    logic [DATA_W-1:0] pc_out;
    logic [3:0]        flags_in;
    logic [3:0]        flags_we;
    logic [3:0]        flags_out;

    modport master (
        output in_enable, sel_in, in_reg, ld_enable, ld_sel, ld_data,
               rsv_enable, rsv_sel, sel_p0, sel_p1, pc_enable, flags_in, flags_we,
        input  p0, p1, p0_busy, p1_busy, pc_out, flags_out
    );

    modport slave (
        input  in_enable, sel_in, in_reg, ld_enable, ld_sel, ld_data,
               rsv_enable, rsv_sel, sel_p0, sel_p1, pc_enable, flags_in, flags_we,
        output p0, p1, p0_busy, p1_busy, pc_out, flags_out
    );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with pending-bit scoreboard, PC and NZCV flags
//
// Purpose : NUM_REGS x DATA_W registers with two write ports (ALU, load), two
//           combinational read ports, a per-register pending scoreboard, an
//           auto-incrementing PC in the top register and a 4-bit flag register.
// Ports   : clock   - rising-edge clock
//           reset_n - asynchronous active-low reset
//           bus     - reg_file_sb_if.slave (write/reserve/read/PC/flag signals)
// Options : REG_FILE_BYPASS_EN - forward same-cycle write data and load-clear
//           onto the read ports and busy outputs.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter int PC_STEP  = 4,
    parameter int RESET_PC = 0
) (
    input  logic          clock,
    input  logic          reset_n,
    reg_file_sb_if.slave  bus
);
    localparam int PC_IDX = NUM_REGS - 1;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic [3:0]          r_flags;

    logic [DATA_W-1:0]   w_next [NUM_REGS];
    logic [NUM_REGS-1:0] w_ld_mask;
    logic [NUM_REGS-1:0] w_rsv_mask;
    logic [NUM_REGS-1:0] w_pend_next;

    // Next value of every register. Later assignments take priority:
    // PC increment < load port < ALU port.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_next[i] = r_regs[i];
            if (i == PC_IDX && bus.pc_enable)
                w_next[i] = r_regs[i] + DATA_W'(PC_STEP);
            if (bus.ld_enable && bus.ld_sel == SEL_W'(i))
                w_next[i] = bus.ld_data;
            if (bus.in_enable && bus.sel_in == SEL_W'(i))
                w_next[i] = bus.in_reg;
        end
    end

    assign w_ld_mask   = NUM_REGS'(bus.ld_enable)  << bus.ld_sel;
    assign w_rsv_mask  = NUM_REGS'(bus.rsv_enable) << bus.rsv_sel;
    // Set is applied after clear so a same-cycle reserve wins over a load.
    assign w_pend_next = (r_pend & ~w_ld_mask) | w_rsv_mask;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= (i == PC_IDX) ? DATA_W'(RESET_PC) : '0;
            r_pend  <= '0;
            r_flags <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= w_next[i];
            r_pend  <= w_pend_next;
            r_flags <= (r_flags & ~bus.flags_we) | (bus.flags_in & bus.flags_we);
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // w_next equals the stored value for untouched registers, so it doubles
    // as the forwarding mux.
    assign bus.p0      = w_next[bus.sel_p0];
    assign bus.p1      = w_next[bus.sel_p1];
    assign bus.p0_busy = r_pend[bus.sel_p0] & ~w_ld_mask[bus.sel_p0];
    assign bus.p1_busy = r_pend[bus.sel_p1] & ~w_ld_mask[bus.sel_p1];
`else
    assign bus.p0      = r_regs[bus.sel_p0];
    assign bus.p1      = r_regs[bus.sel_p1];
    assign bus.p0_busy = r_pend[bus.sel_p0];
    assign bus.p1_busy = r_pend[bus.sel_p1];
`endif

    assign bus.pc_out    = r_regs[PC_IDX];
    assign bus.flags_out = r_flags;
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32, width of every register and data port.
REQ-002 Parameter NUM_REGS, default 16, register count; power of two, >= 4.
REQ-003 Parameter SEL_W, default $clog2(NUM_REGS), width of every select port.
REQ-004 Parameter PC_STEP, default 4, PC auto-increment amount.
REQ-005 Parameter RESET_PC, default 0, PC value after reset.
REQ-006 clock  in  1  single clock; all state updates on rising edge.
REQ-007 reset_n  in  1  the reset is asynchronous and active-low.
REQ-008 in_enable  in  1  ALU write port enable.
REQ-009 sel_in  in  SEL_W  ALU write port register index.
REQ-010 in_reg  in  DATA_W  ALU write port data.
REQ-011 ld_enable  in  1  load write port enable; also clears the scoreboard bit.
REQ-012 ld_sel  in  SEL_W  load write port register index.
REQ-013 ld_data  in  DATA_W  load write port data.
REQ-014 rsv_enable  in  1  reserve request; marks a register pending.
REQ-015 rsv_sel  in  SEL_W  register index to reserve.
REQ-016 sel_p0, sel_p1  in  SEL_W each  read port indices.
REQ-017 p0, p1  out  DATA_W each  read port data.
REQ-018 p0_busy, p1_busy  out  1 each  selected register is pending.
REQ-019 pc_enable  in  1  advance PC by PC_STEP.
REQ-020 pc_out  out  DATA_W  current value of register NUM_REGS-1 (PC).
REQ-021 flags_in  in  4  new NZCV value.
REQ-022 flags_we  in  4  per-bit flag write mask.
REQ-023 flags_out  out  4  current NZCV flags.

Function
REQ-024 Reads: p0/p1/busy outputs combinational from sel_p0/sel_p1; zero-cycle read latency.
REQ-025 Writes: one-cycle latency; data visible on p0/p1 the cycle after the enabling edge.
REQ-026 Both write ports targeting the same index in one cycle: in_reg port value stored.
REQ-027 Scoreboard: one pending bit per register; rsv_enable sets bit rsv_sel at the edge.
REQ-028 ld_enable clears bit ld_sel at the edge; in_enable does not touch the scoreboard.
REQ-029 rsv_enable and ld_enable same index same cycle: bit ends set (reserve wins).
REQ-030 Reserve of an already-pending register: no change; no error indication.
REQ-031 PC: any write port targeting NUM_REGS-1 overrides increment that cycle.
REQ-032 PC: else pc_enable adds PC_STEP, wrapping modulo 2^DATA_W; else PC holds.
REQ-033 Flags: bit i of flags_out loads flags_in[i] only when flags_we[i]=1; others hold.
REQ-034 Writes with both enables low, and flags_we=0, leave all state unchanged.

Reset
REQ-035 reset_n low asynchronously forces all registers to 0, PC to RESET_PC, scoreboard to 0, flags to 0.
REQ-036 Reset asserted mid-operation discards any same-cycle write; first write honoured on first edge after release.

Configuration
REQ-037 Macro REG_FILE_BYPASS_EN defined: p0/p1 return the same-cycle write data when the read index matches an enabled write port (in_reg priority over ld_data; PC increment result also forwarded for index NUM_REGS-1).
REQ-038 With REG_FILE_BYPASS_EN defined, pX_busy reads 0 when ld_enable writes the selected index that cycle.
REQ-039 Macro not defined: reads return stored values only; busy reflects registered scoreboard only.

Verification
REQ-040 Reset, then in_enable=1 sel_in=0 in_reg=32'h12345678, sel_p0=0 -> p0=32'h12345678 one cycle later (bypass off: 0 during write cycle).
REQ-041 in_enable and ld_enable both index 1, in_reg=32'h87654321, ld_data=32'hDEADBEEF -> r1=32'h87654321.
REQ-042 rsv_enable sel 3 -> p1_busy=1 with sel_p1=3; ld_enable sel 3 ld_data=32'h55 -> p1_busy=0, p1=32'h55; rsv+ld same cycle on 3 -> busy stays 1.
REQ-043 PC=32'hFFFFFFFC, pc_enable=1 -> pc_out=0; pc_enable=1 with in_enable sel_in=15 in_reg=32'hABCD1234 -> pc_out=32'hABCD1234.
REQ-044 flags_in=4'b1100 flags_we=4'b1010 from 0 -> flags_out=4'b1000.
REQ-045 reset_n low between edges after writes -> all outputs zero (pc_out=RESET_PC) immediately, before next clock edge.
